// File: rtl/execute_stage.sv
// Execute stage of the 5-stage RV32I pipeline: ID/EX register, operand forwarding,
// ALU, branch/jump resolution with fetch redirect, and the EX/MEM register.
module execute_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             FlushE,
    input  logic             RegWriteD,
    input  logic             MemWriteD,
    input  logic             JumpD,
    input  logic             BranchD,
    input  logic             ALUSrcD,
    input  logic             JALRctrlD,
    input  logic [1:0]       ResultSrcD,
    input  logic [2:0]       ALUControlD,
    input  logic [2:0]       funct3D,
    input  logic [WIDTH-1:0] RD1D,
    input  logic [WIDTH-1:0] RD2D,
    input  logic [WIDTH-1:0] PCD,
    input  logic [WIDTH-1:0] PCPlus4D,
    input  logic [WIDTH-1:0] ImmExtD,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    input  logic [1:0]       ForwardAE,
    input  logic [1:0]       ForwardBE,
    input  logic [WIDTH-1:0] ResultW,
    output logic             PCSrcE,
    output logic [WIDTH-1:0] PCTargetE,
    output logic [4:0]       Rs1E,
    output logic [4:0]       Rs2E,
    output logic [4:0]       RdE,
    output logic             ResultSrcE0,
    output logic             RegWriteM,
    output logic             MemWriteM,
    output logic [1:0]       ResultSrcM,
    output logic [WIDTH-1:0] ALUResultM,
    output logic [WIDTH-1:0] WriteDataM,
    output logic [WIDTH-1:0] PCPlus4M,
    output logic [4:0]       RdM
);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [1:0] FWD_RESULTW = 2'b01;
    localparam logic [1:0] FWD_ALUM    = 2'b10;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    logic             RegWriteE;
    logic             MemWriteE;
    logic             JumpE;
    logic             BranchE;
    logic             ALUSrcE;
    logic             JALRctrlE;
    logic [1:0]       ResultSrcE;
    logic [2:0]       ALUControlE;
    logic [2:0]       funct3E;
    logic [WIDTH-1:0] RD1E;
    logic [WIDTH-1:0] RD2E;
    logic [WIDTH-1:0] PCE;
    logic [WIDTH-1:0] PCPlus4E;
    logic [WIDTH-1:0] ImmExtE;

    logic [WIDTH-1:0] SrcAE;
    logic [WIDTH-1:0] SrcBE;
    logic [WIDTH-1:0] WriteDataE;
    logic [WIDTH-1:0] ALUResultE;
    logic [WIDTH-1:0] jalrSum;
    logic             branchCond;
    logic             lessThan;

    // ID/EX control fields; a flush zeroes them so the bubble can never write or redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUSrcE     <= 1'b0;
            JALRctrlE   <= 1'b0;
            ResultSrcE  <= 2'b00;
            ALUControlE <= 3'b000;
            funct3E     <= 3'b000;
        end else if (FlushE) begin
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUSrcE     <= 1'b0;
            JALRctrlE   <= 1'b0;
            ResultSrcE  <= 2'b00;
            ALUControlE <= 3'b000;
            funct3E     <= 3'b000;
        end else begin
            RegWriteE   <= RegWriteD;
            MemWriteE   <= MemWriteD;
            JumpE       <= JumpD;
            BranchE     <= BranchD;
            ALUSrcE     <= ALUSrcD;
            JALRctrlE   <= JALRctrlD;
            ResultSrcE  <= ResultSrcD;
            ALUControlE <= ALUControlD;
            funct3E     <= funct3D;
        end
    end

    // ID/EX data fields are cleared on flush too, so the hazard unit sees Rs/Rd of 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RD1E     <= '0;
            RD2E     <= '0;
            PCE      <= '0;
            PCPlus4E <= '0;
            ImmExtE  <= '0;
            Rs1E     <= 5'd0;
            Rs2E     <= 5'd0;
            RdE      <= 5'd0;
        end else if (FlushE) begin
            RD1E     <= '0;
            RD2E     <= '0;
            PCE      <= '0;
            PCPlus4E <= '0;
            ImmExtE  <= '0;
            Rs1E     <= 5'd0;
            Rs2E     <= 5'd0;
            RdE      <= 5'd0;
        end else begin
            RD1E     <= RD1D;
            RD2E     <= RD2D;
            PCE      <= PCD;
            PCPlus4E <= PCPlus4D;
            ImmExtE  <= ImmExtD;
            Rs1E     <= Rs1D;
            Rs2E     <= Rs2D;
            RdE      <= RdD;
        end
    end

    always_comb begin
        SrcAE = RD1E;
        case (ForwardAE)
            FWD_RESULTW: SrcAE = ResultW;
            FWD_ALUM:    SrcAE = ALUResultM;
            default:     SrcAE = RD1E;
        endcase
    end

    always_comb begin
        WriteDataE = RD2E;
        case (ForwardBE)
            FWD_RESULTW: WriteDataE = ResultW;
            FWD_ALUM:    WriteDataE = ALUResultM;
            default:     WriteDataE = RD2E;
        endcase
    end

    assign SrcBE    = ALUSrcE ? ImmExtE : WriteDataE;
    assign lessThan = ($signed(SrcAE) < $signed(SrcBE));

    always_comb begin
        ALUResultE = '0;
        case (ALUControlE)
            ALU_ADD: ALUResultE = SrcAE + SrcBE;
            ALU_SUB: ALUResultE = SrcAE - SrcBE;
            ALU_AND: ALUResultE = SrcAE & SrcBE;
            ALU_OR:  ALUResultE = SrcAE | SrcBE;
            ALU_XOR: ALUResultE = SrcAE ^ SrcBE;
            ALU_SLT: ALUResultE = {{(WIDTH-1){1'b0}}, lessThan};
            ALU_SLL: ALUResultE = SrcAE << SrcBE[4:0];
            ALU_SRL: ALUResultE = SrcAE >> SrcBE[4:0];
            default: ALUResultE = '0;
        endcase
    end

    // Branches compare the forwarded register operands, not SrcBE, so an immediate never leaks in
    always_comb begin
        branchCond = 1'b0;
        case (funct3E)
            F3_BEQ:  branchCond = (SrcAE == WriteDataE);
            F3_BNE:  branchCond = (SrcAE != WriteDataE);
            default: branchCond = 1'b0;
        endcase
    end

    assign jalrSum     = SrcAE + ImmExtE;
    assign PCSrcE      = JumpE | (BranchE & branchCond);
    assign PCTargetE   = JALRctrlE ? (jalrSum & ~{{(WIDTH-1){1'b0}}, 1'b1}) : (PCE + ImmExtE);
    assign ResultSrcE0 = ResultSrcE[0];

    // EX/MEM loads unconditionally; a redirect flushes younger instructions, not this one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 2'b00;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
            RdM        <= 5'd0;
        end else begin
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            ALUResultM <= ALUResultE;
            WriteDataM <= WriteDataE;
            PCPlus4M   <= PCPlus4E;
            RdM        <= RdE;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: a reference model predicts each E-stage
// result, queues the expected EX/MEM contents and compares them a cycle later.
module tb_execute_stage;

    typedef struct {
        logic        regWrite;
        logic        memWrite;
        logic        jump;
        logic        branch;
        logic        aluSrc;
        logic        jalr;
        logic [1:0]  resultSrc;
        logic [2:0]  aluCtl;
        logic [2:0]  funct3;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [31:0] pcPlus4;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } DecodeInstr;

    typedef struct {
        logic        regWrite;
        logic        memWrite;
        logic [1:0]  resultSrc;
        logic [31:0] aluResult;
        logic [31:0] writeData;
        logic [31:0] pcPlus4;
        logic [4:0]  rd;
    } MemResult;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        FlushE;
    logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, JALRctrlD;
    logic [1:0]  ResultSrcD;
    logic [2:0]  ALUControlD, funct3D;
    logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] ResultW;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic        ResultSrcE0;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;

    int          assertCount = 0;
    int          failCount = 0;
    MemResult    scoreboard[$];
    DecodeInstr  modelE;
    logic [31:0] modelAluM;
    logic        obsPcSrc;
    logic [31:0] obsTarget;

    always #5 clk = ~clk;

    execute_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .FlushE(FlushE),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
        .ALUSrcD(ALUSrcD), .JALRctrlD(JALRctrlD), .ResultSrcD(ResultSrcD),
        .ALUControlD(ALUControlD), .funct3D(funct3D),
        .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ResultSrcE0(ResultSrcE0),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic DecodeInstr nopInstr();
        DecodeInstr n;
        n.regWrite = 1'b0; n.memWrite = 1'b0; n.jump = 1'b0; n.branch = 1'b0;
        n.aluSrc = 1'b0; n.jalr = 1'b0; n.resultSrc = 2'b00; n.aluCtl = 3'b000;
        n.funct3 = 3'b010; n.rd1 = 32'd0; n.rd2 = 32'd0; n.pc = 32'd0;
        n.pcPlus4 = 32'd0; n.imm = 32'd0; n.rs1 = 5'd0; n.rs2 = 5'd0; n.rd = 5'd0;
        return n;
    endfunction

    function automatic DecodeInstr randInstr();
        DecodeInstr r;
        r.regWrite = 1'($urandom); r.memWrite = 1'($urandom);
        r.jump = ($urandom_range(0, 7) == 0); r.branch = ($urandom_range(0, 3) == 0);
        r.aluSrc = 1'($urandom); r.jalr = 1'($urandom);
        r.resultSrc = 2'($urandom); r.aluCtl = 3'($urandom); r.funct3 = 3'($urandom_range(0, 2));
        r.rd1 = $urandom; r.rd2 = ($urandom_range(0, 1) == 0) ? r.rd1 : $urandom;
        r.pc = $urandom; r.pcPlus4 = r.pc + 32'd4; r.imm = $urandom;
        r.rs1 = 5'($urandom); r.rs2 = 5'($urandom); r.rd = 5'($urandom);
        return r;
    endfunction

    function automatic logic [31:0] fwdVal(input logic [31:0] regVal, input logic [1:0] sel,
                                           input logic [31:0] resW);
        if (sel == 2'b01) return resW;
        if (sel == 2'b10) return modelAluM;
        return regVal;
    endfunction

    function automatic logic [31:0] refAlu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return a ^ b;
            3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b110:  return a << b[4:0];
            default: return a >> b[4:0];
        endcase
    endfunction

    task automatic driveDecode(input DecodeInstr d);
        RegWriteD = d.regWrite; MemWriteD = d.memWrite; JumpD = d.jump; BranchD = d.branch;
        ALUSrcD = d.aluSrc; JALRctrlD = d.jalr; ResultSrcD = d.resultSrc;
        ALUControlD = d.aluCtl; funct3D = d.funct3;
        RD1D = d.rd1; RD2D = d.rd2; PCD = d.pc; PCPlus4D = d.pcPlus4; ImmExtD = d.imm;
        Rs1D = d.rs1; Rs2D = d.rs2; RdD = d.rd;
    endtask

    // Drive one instruction into D and forward selects for the instruction in E, then clock
    task automatic applyStimulus(input DecodeInstr d, input logic flush, input logic [1:0] fwdA,
                                 input logic [1:0] fwdB, input logic [31:0] resW);
        logic [31:0] srcA, wd, srcB, alu, target;
        logic        cond, pcSrc;
        MemResult    exp, got;
        driveDecode(d);
        FlushE = flush; ForwardAE = fwdA; ForwardBE = fwdB; ResultW = resW;
        #1;
        srcA = fwdVal(modelE.rd1, fwdA, resW);
        wd   = fwdVal(modelE.rd2, fwdB, resW);
        srcB = modelE.aluSrc ? modelE.imm : wd;
        alu  = refAlu(modelE.aluCtl, srcA, srcB);
        cond = (modelE.funct3 == 3'b000) ? (srcA == wd) :
               (modelE.funct3 == 3'b001) ? (srcA != wd) : 1'b0;
        pcSrc  = modelE.jump | (modelE.branch & cond);
        target = modelE.jalr ? ((srcA + modelE.imm) & ~32'd1) : (modelE.pc + modelE.imm);
        checkOutput("PCSrcE", 32'(PCSrcE), 32'(pcSrc));
        checkOutput("PCTargetE", PCTargetE, target);
        checkOutput("Rs1E", 32'(Rs1E), 32'(modelE.rs1));
        checkOutput("Rs2E", 32'(Rs2E), 32'(modelE.rs2));
        checkOutput("RdE", 32'(RdE), 32'(modelE.rd));
        checkOutput("ResultSrcE0", 32'(ResultSrcE0), 32'(modelE.resultSrc[0]));
        obsPcSrc = PCSrcE;
        obsTarget = PCTargetE;
        exp.regWrite = modelE.regWrite; exp.memWrite = modelE.memWrite;
        exp.resultSrc = modelE.resultSrc; exp.aluResult = alu; exp.writeData = wd;
        exp.pcPlus4 = modelE.pcPlus4; exp.rd = modelE.rd;
        scoreboard.push_back(exp);
        modelAluM = alu;
        modelE = flush ? nopInstr() : d;
        @(posedge clk);
        #1;
        got = scoreboard.pop_front();
        checkOutput("RegWriteM", 32'(RegWriteM), 32'(got.regWrite));
        checkOutput("MemWriteM", 32'(MemWriteM), 32'(got.memWrite));
        checkOutput("ResultSrcM", 32'(ResultSrcM), 32'(got.resultSrc));
        checkOutput("ALUResultM", ALUResultM, got.aluResult);
        checkOutput("WriteDataM", WriteDataM, got.writeData);
        checkOutput("PCPlus4M", PCPlus4M, got.pcPlus4);
        checkOutput("RdM", 32'(RdM), 32'(got.rd));
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_PCSrcE"}, 32'(PCSrcE), 32'd0);
        checkOutput({tag, "_RegWriteM"}, 32'(RegWriteM), 32'd0);
        checkOutput({tag, "_MemWriteM"}, 32'(MemWriteM), 32'd0);
        checkOutput({tag, "_ALUResultM"}, ALUResultM, 32'd0);
        checkOutput({tag, "_WriteDataM"}, WriteDataM, 32'd0);
        checkOutput({tag, "_PCPlus4M"}, PCPlus4M, 32'd0);
        checkOutput({tag, "_RdM"}, 32'(RdM), 32'd0);
        checkOutput({tag, "_RdE"}, 32'(RdE), 32'd0);
    endtask

    initial begin
        DecodeInstr i, j, b;
        rst_n = 1'b0;
        driveDecode(nopInstr());
        FlushE = 1'b0; ForwardAE = 2'b00; ForwardBE = 2'b00; ResultW = 32'd0;
        modelE = nopInstr();
        modelAluM = 32'd0;
        #3 checkReset("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        i = nopInstr(); i.rd1 = 32'd5; i.rd2 = 32'd7; i.rd = 5'd3; i.regWrite = 1'b1;
        applyStimulus(i, 1'b0, 2'b00, 2'b00, 32'd0);
        applyStimulus(nopInstr(), 1'b0, 2'b00, 2'b00, 32'd0);
        checkOutput("addResult", ALUResultM, 32'd12);
        checkOutput("addRdM", 32'(RdM), 32'd3);
        checkOutput("addRegWriteM", 32'(RegWriteM), 32'd1);

        i = nopInstr(); i.aluSrc = 1'b1; i.imm = 32'h10; i.rd = 5'd1; i.regWrite = 1'b1;
        j = nopInstr(); j.aluSrc = 1'b1; j.imm = 32'd4; j.rd1 = 32'h999; j.rd2 = 32'h777;
        j.rs1 = 5'd1; j.rd = 5'd2; j.memWrite = 1'b1;
        applyStimulus(i, 1'b0, 2'b00, 2'b00, 32'd0);
        applyStimulus(j, 1'b0, 2'b00, 2'b00, 32'd0);
        applyStimulus(nopInstr(), 1'b0, 2'b10, 2'b01, 32'hAA);
        checkOutput("fwdAluResult", ALUResultM, 32'h14);
        checkOutput("fwdWriteData", WriteDataM, 32'hAA);

        b = nopInstr(); b.branch = 1'b1; b.funct3 = 3'b000; b.rd1 = 32'h55; b.rd2 = 32'h55;
        b.pc = 32'h100; b.imm = 32'h20;
        applyStimulus(b, 1'b0, 2'b00, 2'b00, 32'd0);
        i = b; i.funct3 = 3'b001;
        applyStimulus(i, 1'b0, 2'b00, 2'b00, 32'd0);
        checkOutput("beqTaken", 32'(obsPcSrc), 32'd1);
        checkOutput("beqTarget", obsTarget, 32'h120);
        applyStimulus(nopInstr(), 1'b0, 2'b00, 2'b00, 32'd0);
        checkOutput("bneNotTaken", 32'(obsPcSrc), 32'd0);

        j = nopInstr(); j.rd1 = 32'h203; j.imm = 32'd2; j.jump = 1'b1; j.jalr = 1'b1;
        j.pcPlus4 = 32'h48; j.rd = 5'd1; j.regWrite = 1'b1; j.resultSrc = 2'b10;
        applyStimulus(j, 1'b0, 2'b00, 2'b00, 32'd0);
        applyStimulus(nopInstr(), 1'b0, 2'b00, 2'b00, 32'd0);
        checkOutput("jalrTarget", obsTarget, 32'h204);
        checkOutput("jalrTaken", 32'(obsPcSrc), 32'd1);
        checkOutput("jalrPCPlus4M", PCPlus4M, 32'h48);

        i = nopInstr(); i.regWrite = 1'b1; i.memWrite = 1'b1; i.rd = 5'd7; i.jump = 1'b1;
        applyStimulus(i, 1'b1, 2'b00, 2'b00, 32'd0);
        checkOutput("flushRdE", 32'(RdE), 32'd0);
        applyStimulus(nopInstr(), 1'b0, 2'b00, 2'b00, 32'd0);
        checkOutput("flushPCSrcE", 32'(obsPcSrc), 32'd0);
        checkOutput("flushRegWriteM", 32'(RegWriteM), 32'd0);
        checkOutput("flushMemWriteM", 32'(MemWriteM), 32'd0);

        // Taken branch in E while the hazard unit flushes: branch completes, D is dropped
        applyStimulus(b, 1'b0, 2'b00, 2'b00, 32'd0);
        applyStimulus(i, 1'b1, 2'b00, 2'b00, 32'd0);
        checkOutput("flushBranchTaken", 32'(obsPcSrc), 32'd1);
        checkOutput("flushBranchDropRdE", 32'(RdE), 32'd0);
        applyStimulus(nopInstr(), 1'b0, 2'b00, 2'b00, 32'd0);

        for (int n = 0; n < 60; n++) begin
            applyStimulus(randInstr(), ($urandom_range(0, 7) == 0), 2'($urandom), 2'($urandom), $urandom);
        end

        i = nopInstr(); i.jump = 1'b1; i.pc = 32'h40; i.imm = 32'd8; i.regWrite = 1'b1;
        i.rd = 5'd5; i.rd1 = 32'd9;
        applyStimulus(i, 1'b0, 2'b00, 2'b00, 32'd0);
        applyStimulus(i, 1'b0, 2'b00, 2'b00, 32'd0);
        #2 rst_n = 1'b0;
        #1 checkReset("midReset");
        modelE = nopInstr();
        modelAluM = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(nopInstr(), 1'b0, 2'b00, 2'b00, 32'd0);
        checkOutput("postResetBubble", 32'(obsPcSrc), 32'd0);
        applyStimulus(nopInstr(), 1'b0, 2'b00, 2'b00, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
